// File: rtl/tile_wb_pkg.sv
// Shared types and constants for the tile Wishbone fan-out.
package tile_wb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StResp
  } state_e;

  localparam int unsigned STAT_ERR_BIT  = 31;
  localparam int unsigned STAT_TCNT_LSB = 16;
  localparam int unsigned STAT_IDX_LSB  = 0;

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

  function automatic logic [31:0] pack_status(input logic err, input logic [7:0] tcnt,
                                              input logic [7:0] last_idx);
    logic [31:0] w;
    w = '0;
    w[STAT_ERR_BIT]            = err;
    w[STAT_TCNT_LSB +: 8]      = tcnt;
    w[STAT_IDX_LSB +: 8]       = last_idx;
    return w;
  endfunction

endpackage

// File: rtl/tile_wb_ack_collect.sv
// Per-tile strobe register and accumulated ack mask for one fan-out transaction.
module tile_wb_ack_collect #(
  parameter int unsigned N = 64
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [N-1:0] load_mask_i,
  input  logic         clear_i,
  input  logic [N-1:0] ack_i,
  output logic [N-1:0] stb_o,
  output logic [N-1:0] ack_hit_o,
  output logic [N-1:0] ack_acc_o,
  output logic         all_acked_o
);

  logic [N-1:0] stb_q, stb_d;
  logic [N-1:0] mask_q, mask_d;

  always_comb begin
    ack_hit_o = ack_i & stb_q;
    ack_acc_o = mask_q | ack_hit_o;
    mask_d    = ack_acc_o;
    // An acked tile loses its strobe on the following cycle.
    stb_d     = stb_q & ~ack_i;
    if (clear_i) begin
      stb_d = '0;
    end
    if (load_i) begin
      stb_d  = load_mask_i;
      mask_d = '0;
    end
  end

  assign all_acked_o = &ack_acc_o;
  assign stb_o       = stb_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stb_q  <= '0;
      mask_q <= '0;
    end else begin
      stb_q  <= stb_d;
      mask_q <= mask_d;
    end
  end

endmodule

// File: rtl/tile_wb_fanout.sv
// Registered Wishbone fan-out to N_TILES tile slaves with broadcast writes,
// ack timeout and a read-clear status word.
module tile_wb_fanout
  import tile_wb_pkg::*;
#(
  parameter int unsigned N_TILES   = 64,
  parameter int unsigned SEL_LSB   = 4,
  parameter int unsigned BCAST_BIT = 12,
  parameter int unsigned TIMEOUT   = 255,
  parameter logic [31:0] ERR_DATA  = ERR_DATA_DEFAULT
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  wbs_stb_i,
  input  logic                  wbs_cyc_i,
  input  logic                  wbs_we_i,
  input  logic [3:0]            wbs_sel_i,
  input  logic [31:0]           wbs_dat_i,
  input  logic [31:0]           wbs_adr_i,
  output logic                  wbs_ack_o,
  output logic [31:0]           wbs_dat_o,
  output logic [N_TILES-1:0]    tri_wbs_stb_o,
  output logic                  tri_wbs_we_o,
  output logic [3:0]            tri_wbs_sel_o,
  output logic [31:0]           tri_wbs_dat_o,
  output logic [3:0]            tri_wbs_adr_o,
  input  logic [N_TILES-1:0]    tri_wbs_ack_i,
  input  logic [32*N_TILES-1:0] tri_wbs_dat_i,
  output logic                  err_o
);

  localparam int unsigned IDXW     = (N_TILES > 1) ? $clog2(N_TILES) : 1;
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  state_e             state_q, state_d;
  logic               we_q, we_d, bcast_q, bcast_d, stat_rd_q, stat_rd_d, err_q, err_d;
  logic [3:0]         sel_q, sel_d, adr_q, adr_d;
  logic [31:0]        wdat_q, wdat_d, dat_q, dat_d;
  logic [IDXW-1:0]    idx_q, idx_d;
  logic [15:0]        tmo_q, tmo_d;
  logic [7:0]         tcnt_q, tcnt_d, last_idx_q, last_idx_d;

  logic               load, clear, all_acked;
  logic [N_TILES-1:0] load_mask, onehot, ack_hit, ack_acc;
  logic [IDXW-1:0]    req_idx;
  logic               req_idx_ok;
  logic [31:0]        tile_rdata;
  logic [7:0]         low_unacked;
  logic               unused_adr;

  assign req_idx    = wbs_adr_i[SEL_LSB +: IDXW];
  assign req_idx_ok = 32'(req_idx) < N_TILES;
  assign unused_adr = ^wbs_adr_i;

  always_comb begin
    onehot      = '0;
    tile_rdata  = '0;
    low_unacked = '0;
    for (int i = 0; i < int'(N_TILES); i++) begin
      onehot[i] = (req_idx == IDXW'(i));
      if (idx_q == IDXW'(i)) begin
        tile_rdata = tri_wbs_dat_i[32*i +: 32];
      end
    end
    for (int i = int'(N_TILES) - 1; i >= 0; i--) begin
      if (!ack_acc[i]) begin
        low_unacked = 8'(i);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    sel_d      = sel_q;
    wdat_d     = wdat_q;
    adr_d      = adr_q;
    idx_d      = idx_q;
    bcast_d    = bcast_q;
    stat_rd_d  = stat_rd_q;
    tmo_d      = tmo_q;
    dat_d      = dat_q;
    err_d      = err_q;
    tcnt_d     = tcnt_q;
    last_idx_d = last_idx_q;
    load       = 1'b0;
    load_mask  = '0;
    clear      = 1'b0;

    case (state_q)
      StIdle: begin
        if (wbs_stb_i && wbs_cyc_i) begin
          we_d      = wbs_we_i;
          sel_d     = wbs_sel_i;
          wdat_d    = wbs_dat_i;
          adr_d     = wbs_adr_i[3:0];
          idx_d     = req_idx;
          bcast_d   = wbs_adr_i[BCAST_BIT];
          stat_rd_d = wbs_adr_i[BCAST_BIT] && !wbs_we_i;
          tmo_d     = '0;
          if (!wbs_adr_i[BCAST_BIT]) begin
            if (req_idx_ok) begin
              load      = 1'b1;
              load_mask = onehot;
              state_d   = StIssue;
            end else begin
              dat_d   = ERR_DATA;
              err_d   = 1'b1;
              state_d = StResp;
            end
          end else if (wbs_we_i) begin
            load      = 1'b1;
            load_mask = '1;
            state_d   = StIssue;
          end else begin
            dat_d   = pack_status(err_q, tcnt_q, last_idx_q);
            state_d = StResp;
          end
        end
      end
      StIssue: begin
        tmo_d = tmo_q + 16'd1;
        if (!wbs_cyc_i) begin
          clear   = 1'b1;
          state_d = StIdle;
        end else if (bcast_q ? all_acked : |ack_hit) begin
          // Completion is checked before expiry so a late ack still wins.
          clear   = 1'b1;
          dat_d   = bcast_q ? 32'h0 : tile_rdata;
          state_d = StResp;
        end else if (tmo_q == TMO_LAST) begin
          clear      = 1'b1;
          dat_d      = ERR_DATA;
          err_d      = 1'b1;
          tcnt_d     = (tcnt_q == 8'hFF) ? 8'hFF : tcnt_q + 8'd1;
          last_idx_d = bcast_q ? low_unacked : 8'(idx_q);
          state_d    = StResp;
        end
      end
      StResp: begin
        state_d = StIdle;
        if (stat_rd_q) begin
          err_d  = 1'b0;
          tcnt_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  tile_wb_ack_collect #(
    .N (N_TILES)
  ) u_ack_collect (
    .clk_i       (wb_clk_i),
    .rst_i       (wb_rst_i),
    .load_i      (load),
    .load_mask_i (load_mask),
    .clear_i     (clear),
    .ack_i       (tri_wbs_ack_i),
    .stb_o       (tri_wbs_stb_o),
    .ack_hit_o   (ack_hit),
    .ack_acc_o   (ack_acc),
    .all_acked_o (all_acked)
  );

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q    <= StIdle;
      we_q       <= 1'b0;
      sel_q      <= '0;
      wdat_q     <= '0;
      adr_q      <= '0;
      idx_q      <= '0;
      bcast_q    <= 1'b0;
      stat_rd_q  <= 1'b0;
      tmo_q      <= '0;
      dat_q      <= '0;
      err_q      <= 1'b0;
      tcnt_q     <= '0;
      last_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      sel_q      <= sel_d;
      wdat_q     <= wdat_d;
      adr_q      <= adr_d;
      idx_q      <= idx_d;
      bcast_q    <= bcast_d;
      stat_rd_q  <= stat_rd_d;
      tmo_q      <= tmo_d;
      dat_q      <= dat_d;
      err_q      <= err_d;
      tcnt_q     <= tcnt_d;
      last_idx_q <= last_idx_d;
    end
  end

  assign wbs_ack_o     = (state_q == StResp);
  assign wbs_dat_o     = dat_q;
  assign tri_wbs_we_o  = we_q;
  assign tri_wbs_sel_o = sel_q;
  assign tri_wbs_dat_o = wdat_q;
  assign tri_wbs_adr_o = adr_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_tile_wb_fanout.sv
// Scoreboard bench for tile_wb_fanout: behavioural tiles with per-tile ack delay.
module tb_tile_wb_fanout;

  localparam int N     = 12;
  localparam int TMO   = 12;
  localparam int NEVER = -1;
  localparam int BUDGET = 60;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            stb = 1'b0, cyc = 1'b0, we = 1'b0;
  logic [3:0]      sel = 4'h0;
  logic [31:0]     wdat = '0, adr = '0;
  logic            ack;
  logic [31:0]     rdat;
  logic [N-1:0]    tri_stb, tri_ack;
  logic            tri_we;
  logic [3:0]      tri_sel, tri_adr;
  logic [31:0]     tri_wdat;
  logic [32*N-1:0] tri_rdat;
  logic            err;

  int          dly[N];
  logic [31:0] tdat[N];
  int          scnt[N];

  int n_chk = 0;
  int n_pass = 0;

  typedef struct {
    logic [31:0] dat;
    int          lat;
    logic [N-1:0] stb;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  tile_wb_fanout #(
    .N_TILES   (N),
    .SEL_LSB   (4),
    .BCAST_BIT (12),
    .TIMEOUT   (TMO),
    .ERR_DATA  (32'hDEAD_BEEF)
  ) dut (
    .wb_clk_i      (clk),
    .wb_rst_i      (rst),
    .wbs_stb_i     (stb),
    .wbs_cyc_i     (cyc),
    .wbs_we_i      (we),
    .wbs_sel_i     (sel),
    .wbs_dat_i     (wdat),
    .wbs_adr_i     (adr),
    .wbs_ack_o     (ack),
    .wbs_dat_o     (rdat),
    .tri_wbs_stb_o (tri_stb),
    .tri_wbs_we_o  (tri_we),
    .tri_wbs_sel_o (tri_sel),
    .tri_wbs_dat_o (tri_wdat),
    .tri_wbs_adr_o (tri_adr),
    .tri_wbs_ack_i (tri_ack),
    .tri_wbs_dat_i (tri_rdat),
    .err_o         (err)
  );

  // Tile i acks (combinationally) once its strobe has been high for dly[i] cycles.
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) scnt[i] <= tri_stb[i] ? scnt[i] + 1 : 0;
  end

  always_comb begin
    tri_ack  = '0;
    tri_rdat = '0;
    for (int i = 0; i < N; i++) begin
      tri_ack[i]         = tri_stb[i] && (dly[i] >= 0) && (scnt[i] >= dly[i]);
      tri_rdat[32*i +: 32] = tdat[i];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // A tile seen acking must have its strobe low on the next cycle.
  logic [N-1:0] prev_hit = '0;
  always begin
    @(posedge clk);
    #1;
    if (|prev_hit) chk("stb_drop", 32'(tri_stb & prev_hit), 32'h0);
    prev_hit = tri_stb & tri_ack;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic xfer(input string tag, input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] exp_dat, input int exp_lat, input logic [N-1:0] exp_stb,
                      input logic exp_err);
    exp_t e, g;
    int n;
    e.dat = exp_dat; e.lat = exp_lat; e.stb = exp_stb;
    sb.push_back(e);
    we = w; adr = a; wdat = d; sel = 4'hF; stb = 1'b1; cyc = 1'b1;
    n = 0;
    do begin
      step();
      n++;
      if (n == 1 && !ack) begin
        chk({tag, "_stb"}, 32'(tri_stb), 32'(sb[0].stb));
        chk({tag, "_tdat"}, tri_wdat, d);
        chk({tag, "_twe"}, 32'(tri_we), 32'(w));
      end
    end while (!ack && n < BUDGET);
    stb = 1'b0; cyc = 1'b0;
    g = sb.pop_front();
    chk({tag, "_lat"}, 32'(n), 32'(g.lat));
    chk({tag, "_dat"}, rdat, g.dat);
    step();
    chk({tag, "_ackpulse"}, 32'(ack), 32'h0);
    chk({tag, "_err"}, 32'(err), 32'(exp_err));
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      dly[i]  = 0;
      tdat[i] = 32'hA000_0000 | 32'(i);
    end
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ack", 32'(ack), 32'h0);
    chk("rst_dat", rdat, 32'h0);
    chk("rst_stb", 32'(tri_stb), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    step();
    rst = 1'b0;
    step();

    // Unicast write to tile 3, acking after 2 strobe cycles.
    dly[3] = 2;
    xfer("uwr", 1'b1, 32'h30, 32'h1234_5678, 32'hA000_0003, 4, 12'h008, 1'b0);

    // Unicast read tile 5 with immediate ack.
    tdat[5] = 32'hCAFE_F00D; dly[5] = 0;
    xfer("urd", 1'b0, 32'h50, 32'h0, 32'hCAFE_F00D, 2, 12'h020, 1'b0);

    // Broadcast write, tile i acks in its (i+1)th strobe cycle; last one lands on expiry.
    for (int i = 0; i < N; i++) dly[i] = i;
    xfer("bwr", 1'b1, 32'h1000, 32'h5555_AAAA, 32'h0, N + 1, 12'hFFF, 1'b0);

    // Unicast read timeout on tile 7, then status read-and-clear.
    for (int i = 0; i < N; i++) dly[i] = 0;
    dly[7] = NEVER;
    xfer("tmo", 1'b0, 32'h70, 32'h0, 32'hDEAD_BEEF, TMO + 1, 12'h080, 1'b1);
    xfer("st1", 1'b0, 32'h1000, 32'h0, 32'h8001_0007, 1, 12'h000, 1'b0);

    // Out-of-range tile index: immediate error response, err set, no timeout count.
    xfer("bad", 1'b0, 32'hD0, 32'h0, 32'hDEAD_BEEF, 1, 12'h000, 1'b1);
    xfer("st2", 1'b0, 32'h1000, 32'h0, 32'h8000_0007, 1, 12'h000, 1'b0);

    // Broadcast timeout with tiles 4 and 9 silent: lowest un-acked is 4.
    dly[7] = 0; dly[4] = NEVER; dly[9] = NEVER;
    xfer("btmo", 1'b1, 32'h1000, 32'h0, 32'hDEAD_BEEF, TMO + 1, 12'hFFF, 1'b1);
    xfer("st3", 1'b0, 32'h1000, 32'h0, 32'h8001_0004, 1, 12'h000, 1'b0);
    dly[4] = 0; dly[9] = 0;

    // Master abort three cycles into ISSUE.
    dly[3] = NEVER;
    we = 1'b0; adr = 32'h30; stb = 1'b1; cyc = 1'b1;
    repeat (3) step();
    chk("abt_stb_before", 32'(tri_stb), 32'h008);
    stb = 1'b0; cyc = 1'b0;
    step();
    chk("abt_stb", 32'(tri_stb), 32'h0);
    for (int i = 0; i < 3; i++) begin
      chk("abt_noack", 32'(ack), 32'h0);
      step();
    end
    chk("abt_err", 32'(err), 32'h0);
    dly[3] = 0;
    xfer("post_abt", 1'b0, 32'h50, 32'h0, 32'hCAFE_F00D, 2, 12'h020, 1'b0);

    // Asynchronous reset in the middle of ISSUE with err_o set.
    xfer("bad2", 1'b0, 32'hE0, 32'h0, 32'hDEAD_BEEF, 1, 12'h000, 1'b1);
    dly[7] = NEVER;
    we = 1'b0; adr = 32'h70; stb = 1'b1; cyc = 1'b1;
    repeat (2) step();
    chk("rst_mid_stb_before", 32'(tri_stb), 32'h080);
    #3;
    rst = 1'b1;
    #1;
    chk("rst_mid_stb", 32'(tri_stb), 32'h0);
    chk("rst_mid_ack", 32'(ack), 32'h0);
    chk("rst_mid_err", 32'(err), 32'h0);
    stb = 1'b0; cyc = 1'b0;
    step();
    rst = 1'b0;
    dly[7] = 0;
    step();
    xfer("post_rst", 1'b0, 32'h50, 32'h0, 32'hCAFE_F00D, 2, 12'h020, 1'b0);

    repeat (2) step();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/tile_wb_fanout.md
Name: tile_wb_fanout

Overview:
Parametrised Wishbone fan-out between the management-side Wishbone slave port and N_TILES tile register slaves. It replaces a purely combinational strobe/ack demux with a registered transaction engine. The engine adds tile read-data return, broadcast writes to all tiles, a per-transaction ack timeout and a status word. It sits between the user-project Wishbone port and the tile array.

Parameters:
N_TILES, 64, number of tile slaves (1..256); IDXW = $clog2(N_TILES), minimum 1
SEL_LSB, 4, lowest address bit of the tile index field
BCAST_BIT, 12, address bit selecting the broadcast/status region; must be greater than SEL_LSB+IDXW-1
TIMEOUT, 255, cycles to wait for tile ack(s) before an error response (1..65535)
ERR_DATA, 32'hDEAD_BEEF, read data returned on timeout or bad index

Ports:
wb_clk_i  in  1  clock
wb_rst_i  in  1  reset, asynchronous, active-high
wbs_stb_i  in  1  master strobe
wbs_cyc_i  in  1  master cycle
wbs_we_i  in  1  write enable
wbs_sel_i  in  4  byte selects, forwarded to tiles
wbs_dat_i  in  32  write data, forwarded to tiles
wbs_adr_i  in  32  address
wbs_ack_o  out  1  one-cycle ack pulse to master
wbs_dat_o  out  32  registered read data
tri_wbs_stb_o  out  N_TILES  per-tile strobe
tri_wbs_we_o  out  1  latched we, shared by all tiles
tri_wbs_sel_o  out  4  latched sel, shared
tri_wbs_dat_o  out  32  latched write data, shared
tri_wbs_adr_o  out  4  latched adr[3:0], shared
tri_wbs_ack_i  in  N_TILES  per-tile ack
tri_wbs_dat_i  in  32*N_TILES  per-tile read data; tile i occupies bits [32i+31:32i]
err_o  out  1  sticky error flag

Behaviour:
- Reset (async): state IDLE; all outputs 0; status counters 0.
- Decode: idx = adr[SEL_LSB+IDXW-1:SEL_LSB]; region = adr[BCAST_BIT].
- FSM states IDLE, ISSUE, RESP.
- IDLE:
  - On stb&cyc, latch we/sel/dat/adr/idx/region.
  - region=0 and idx<N_TILES: go to ISSUE; the chosen tile's strobe is high from the next cycle.
  - region=0 and idx>=N_TILES: go to RESP with error; dat=ERR_DATA; set err_o.
  - region=1, write (broadcast): go to ISSUE; all tile strobes high.
  - region=1, read: go to RESP; dat = status word.
- ISSUE:
  - Each cycle, OR tri_wbs_ack_i & strobe mask into ack_mask. Drop each tile's strobe in the cycle after its ack is seen.
  - Unicast done when its ack is seen: capture that tile's data and go to RESP.
  - Broadcast done when ack_mask covers all tiles; read data is 0.
  - Timeout counter counts cycles in ISSUE. On reaching TIMEOUT, drop all strobes and go to RESP with ERR_DATA. Also: set err_o; saturating-increment timeout_cnt[7:0]; record last_idx (for broadcast, the lowest un-acked index).
- RESP: wbs_ack_o=1 for exactly one cycle with wbs_dat_o valid; then go to IDLE. wbs_dat_o holds its value until the next response.
- Latency: a tile acking combinationally on its first strobe cycle gives master ack 2 cycles after the request is seen. A timeout gives master ack TIMEOUT+1 cycles after the request.
- Master abort: cyc low in ISSUE drops all strobes and returns to IDLE with no ack and no error. A later ack from that tile is ignored.
- No new request is accepted outside IDLE. A request still asserted on return to IDLE is treated as a new transaction only if it arrives after the ack cycle (master-side Wishbone classic rule).
- Status word: [31]=err_o, [23:16]=timeout_cnt, [7:0]=last_idx (zero-extended).
  - A status read clears err_o and timeout_cnt in the RESP cycle.
  - A new error in the same cycle wins (sets err_o, count becomes 1).
- Ack arriving in the same cycle as timeout expiry: the ack wins.

Decomposition:
- Package tile_wb_pkg holds:
  - FSM state enum.
  - Status-word field offsets.
  - ERR_DATA default.
- Sub-module tile_wb_ack_collect (ack_mask register, strobe mask and all-acked detection) is natural.
- The read-data mux and timeout counter stay in the top module.

Test Plan:
- Unicast write adr=0x30 (idx 3), dat=0x12345678; tile 3 acks after 2 cycles -> only strobe bit 3 is high; tri dat=0x12345678; one master ack; err_o=0.
- Unicast read idx 5; tile 5 drives 0xCAFEF00D with immediate ack -> master ack 2 cycles after request; wbs_dat_o=0xCAFEF00D.
- Broadcast write adr=0x1000; tiles ack at staggered cycles 1..N -> each strobe drops after its ack; master ack only after the last; data 0.
- Read idx 7; tile never acks; TIMEOUT=8 -> ack at cycle 9 with 0xDEADBEEF; err_o=1; status read returns 0x8001_0007, then err_o=0.
- Master drops cyc 3 cycles into ISSUE -> strobes low next cycle; no ack; FSM in IDLE.
- Assert wb_rst_i mid-ISSUE -> all strobes, ack and err_o go low immediately (asynchronous); the next transaction completes normally.
